// File: rtl/mem_region_router.sv
// Memory-map router: decodes LSU requests onto NREGIONS targets with per-region
// wait states and write permission, and returns one registered response per request.
module mem_region_router #(
  parameter int                         XLEN             = 32,
  parameter int                         NREGIONS         = 4,
  parameter logic [NREGIONS*XLEN-1:0]   REGION_BASE      = {32'h20000, 32'h10000, 32'h800, 32'h0},
  parameter logic [NREGIONS*5-1:0]      REGION_SIZE_LOG2 = {5'd4, 5'd8, 5'd10, 5'd11},
  parameter logic [NREGIONS*4-1:0]      REGION_WAIT      = {4'd0, 4'd3, 4'd1, 4'd0},
  parameter logic [NREGIONS-1:0]        REGION_WRITABLE  = 4'b1110
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [XLEN-1:0]            req_addr,
  input  logic                       req_wen,
  input  logic [1:0]                 req_wwidth,
  input  logic [XLEN-1:0]            req_wdata,
  output logic                       resp_valid,
  output logic [XLEN-1:0]            resp_rdata,
  output logic                       resp_fault,
  output logic [1:0]                 resp_cause,
  output logic [NREGIONS-1:0]        dev_sel,
  output logic [XLEN-1:0]            dev_addr,
  output logic                       dev_wen,
  output logic [1:0]                 dev_wwidth,
  output logic [XLEN-1:0]            dev_wdata,
  input  logic [NREGIONS*XLEN-1:0]   dev_rdata
);

  localparam int RW = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;

  // write_width_t encoding: 0 byte, 1 half, 2 word
  localparam logic [1:0] WW_HALF = 2'd1;
  localparam logic [1:0] WW_WORD = 2'd2;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_UNMAPPED = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_RDONLY   = 2'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [RW-1:0]   region_q;
  logic            wen_q;

  logic            hit;
  logic [RW-1:0]   hit_idx;
  logic [XLEN-1:0] hit_base;
  logic [3:0]      hit_wait;
  logic            hit_wr;
  logic            misaligned;
  logic [1:0]      cause;
  logic [XLEN-1:0] sel_rdata;

  assign req_ready = (state == IDLE);

  // Scan from the top down so the lowest matching index wins on overlap.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    hit_wait = '0;
    hit_wr   = 1'b0;
    for (int r = NREGIONS - 1; r >= 0; r--) begin
      if ((req_addr >> REGION_SIZE_LOG2[r*5 +: 5]) ==
          (REGION_BASE[r*XLEN +: XLEN] >> REGION_SIZE_LOG2[r*5 +: 5])) begin
        hit      = 1'b1;
        hit_idx  = RW'(r);
        hit_base = REGION_BASE[r*XLEN +: XLEN];
        hit_wait = REGION_WAIT[r*4 +: 4];
        hit_wr   = REGION_WRITABLE[r];
      end
    end
  end

  always_comb begin
    misaligned = req_wen && (((req_wwidth == WW_HALF) && req_addr[0]) ||
                             ((req_wwidth == WW_WORD) && (req_addr[1:0] != 2'b00)));
    if (!hit)                   cause = CAUSE_UNMAPPED;
    else if (misaligned)        cause = CAUSE_MISALIGN;
    else if (req_wen && !hit_wr) cause = CAUSE_RDONLY;
    else                        cause = CAUSE_NONE;
  end

  always_comb begin
    sel_rdata = '0;
    for (int r = 0; r < NREGIONS; r++) begin
      if (region_q == RW'(r)) sel_rdata = dev_rdata[r*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      region_q   <= '0;
      wen_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      resp_cause <= CAUSE_NONE;
      dev_sel    <= '0;
      dev_addr   <= '0;
      dev_wen    <= 1'b0;
      dev_wwidth <= '0;
      dev_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (cause != CAUSE_NONE) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_cause <= cause;
              resp_rdata <= '0;
            end else begin
              state      <= ACCESS;
              cnt        <= hit_wait;
              region_q   <= hit_idx;
              wen_q      <= req_wen;
              dev_sel    <= NREGIONS'(1) << hit_idx;
              dev_addr   <= req_addr - hit_base;
              dev_wen    <= req_wen;
              dev_wwidth <= req_wwidth;
              dev_wdata  <= req_wdata;
            end
          end
        end
        ACCESS: begin
          // Write strobe lasts one cycle; select is held through the wait states.
          dev_wen <= 1'b0;
          if (cnt == 4'd0) begin
            state      <= RESP;
            dev_sel    <= '0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_cause <= CAUSE_NONE;
            resp_rdata <= wen_q ? '0 : sel_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_cause <= CAUSE_NONE;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_region_router.md
# mem_region_router

Parametrised memory-map router between the hart's load/store unit and N memory-mapped targets (ROM, RAM, MMIO). Generalises the fixed two-region ROM/RAM split to NREGIONS regions with per-region base, size, wait states and write permission. It adds a valid/ready request handshake, a registered response, and access-fault reporting for unmapped, misaligned and read-only writes. It sits directly below the hart's memory stage and fans out to the ROM, RAM and peripheral blocks.

## Interface
- XLEN, 32, address/data width (from isa_types)
- NREGIONS, 4, number of target regions
- REGION_BASE, {32'h20000, 32'h10000, 32'h800, 32'h0}, packed NREGIONS×XLEN base addresses; index 0 in the low slice
- REGION_SIZE_LOG2, {5'd4, 5'd8, 5'd10, 5'd11}, packed NREGIONS×5 region size as log2 bytes; each base aligned to its size
- REGION_WAIT, {4'd0, 4'd3, 4'd1, 4'd0}, packed NREGIONS×4 extra wait cycles per access
- REGION_WRITABLE, 4'b1110, bit r set = region r accepts writes (region 0 = ROM)
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  router idle, request accepted when req_valid & req_ready
- req_addr  in  XLEN  byte address
- req_wen  in  1  1 = write, 0 = read
- req_wwidth  in  write_width_t  byte/half/word write width
- req_wdata  in  XLEN  write data
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  XLEN  read data (0 for writes and faults)
- resp_fault  out  1  access faulted, no target touched
- resp_cause  out  2  1 unmapped, 2 misaligned write, 3 write to read-only; 0 when no fault
- dev_sel  out  NREGIONS  one-hot target select
- dev_addr  out  XLEN  address minus selected region base
- dev_wen  out  1  write strobe to selected target
- dev_wwidth  out  write_width_t  latched width
- dev_wdata  out  XLEN  latched write data
- dev_rdata  in  NREGIONS×XLEN  per-target read data, target r in slice r

## Operation
- FSM states: IDLE, ACCESS, RESP. req_ready = (state == IDLE).
- IDLE: on handshake, latch addr/wen/wwidth/wdata; decode region = lowest index r with (addr >> SIZE_LOG2[r]) == (BASE[r] >> SIZE_LOG2[r]).
- Fault check, priority unmapped > misaligned > read-only. Misaligned: write with half and addr[0]≠0, or word and addr[1:0]≠0. Reads are never misaligned (full-word fetch).
- Fault → RESP with resp_fault=1, resp_cause set; dev_sel stays 0.
- No fault → ACCESS, wait counter loaded with REGION_WAIT[r].
- ACCESS: dev_sel one-hot held for WAIT+1 cycles. dev_addr/dev_wdata/dev_wwidth are stable. dev_wen is high only in the first ACCESS cycle. Counter decrements each cycle. When the counter is 0, capture dev_rdata slice r into the resp_rdata register (reads only), then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_fault/resp_cause are valid only while resp_valid; otherwise 0.
- Address offset subtraction wraps modulo 2^XLEN. Only in-region addresses reach targets.

## Timing
- Reset (async assert): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, resp_cause=0, dev_sel=0, dev_wen=0, dev_addr=0, dev_wdata=0, dev_wwidth=0, counter=0.
- Reset mid-ACCESS: dev_wen and dev_sel drop immediately; the in-flight response is discarded.
- Handshake in cycle T, no fault: ACCESS cycles T+1 … T+1+WAIT, resp_valid at T+2+WAIT.
- Handshake in cycle T, fault: resp_valid at T+1.
- Back-to-back: the next request can be accepted in the cycle after resp_valid. Throughput is 1 request per WAIT+3 cycles.
- req_valid while not ready is ignored. The requester holds it until accepted.

## Test plan
- Read 0x004, dev_rdata[0]=0xDEADBEEF → dev_sel=0001 one cycle, dev_addr=0x4, resp_valid at T+2 with rdata 0xDEADBEEF, fault 0.
- Word write 0x10008 ← 0x12345678 → dev_sel=0100 for 4 cycles, dev_wen high first cycle only, dev_addr=0x8, resp_valid at T+5.
- Write 0x000 (ROM) → resp_valid T+1, fault 1, cause 3, dev_sel never asserted.
- Read 0x30000 → fault 1, cause 1. Half write 0x801 → fault 1, cause 2.
- req_valid held continuously over alternating 0x800/0x20000 reads → req_ready low except IDLE, responses spaced 4 and 3 cycles, no dropped or duplicated responses.
- reset_n pulsed low during the 2nd ACCESS cycle at 0x10000 → dev_sel=0 and dev_wen=0 immediately, no resp_valid, req_ready=1 after release.
